register_file_mp: RTL
=====================

// Module: register_file_mp
// PURPOSE
//  Parametrised multi-port register file for the 16-bit processor datapath: 2 async read ports, 2 write ports.
//  Self-clears all entries after reset, exposes busy; write-first bypass on reads; flags same-address writes.
//  Sits between decode (read addresses) and writeback (ALU + load result write ports).
// PARAMETERS
//  DATA_W   16   bits per register
//  ADDR_W   4    address bits; DEPTH = 2**ADDR_W entries
// PORTS
//  clock        in   1       single clock; all state updates on rising edge
//  reset_n      in   1       synchronous, active-low reset
//  wrAddrA      in   ADDR_W  write port A address
//  wrDataA      in   DATA_W  write port A data
//  writeA       in   1       write port A enable
//  wrAddrB      in   ADDR_W  write port B address (priority port)
//  wrDataB      in   DATA_W  write port B data
//  writeB       in   1       write port B enable
//  rdAddrA      in   ADDR_W  read port A address
//  rdAddrB      in   ADDR_W  read port B address
//  rdDataA      out  DATA_W  read port A data (combinational)
//  rdDataB      out  DATA_W  read port B data (combinational)
//  busy         out  1       1 while reset held or clear sweep running; writes ignored
//  collision    out  1       registered 1-cycle pulse: both ports wrote same address
// BEHAVIOUR
//  - FSM states CLEAR, READY. reset_n=0 at an edge: state<=CLEAR, clrCnt<=0, collision<=0; busy=1.
//  - CLEAR, reset_n=1: mem[clrCnt]<=0, clrCnt++; at clrCnt==DEPTH-1 -> READY. Sweep = DEPTH cycles.
//  - busy = (state==CLEAR) | ~reset_n (combinational); busy falls DEPTH edges after reset release.
//  - Reset reasserted mid-sweep or in READY: sweep restarts at entry 0; no partial-clear state survives.
//  - While busy: writeA/writeB ignored, rdDataA/B = 0, collision stays 0.
//  - READY: writeA -> mem[wrAddrA]<=wrDataA; writeB -> mem[wrAddrB]<=wrDataB, same edge.
//  - Same-address write (both enables, wrAddrA==wrAddrB): port B wins; collision=1 for next cycle only.
//  - Read path (READY): if writeB & wrAddrB==rdAddr -> wrDataB; else if writeA & wrAddrA==rdAddr -> wrDataA;
//    else mem[rdAddr]. Bypass is combinational, zero-latency (write-first). Ports A/B independent.
//  - Write-to-read latency 0 via bypass; stored value visible from mem on cycle after the write edge.
//  - Widths exact: no truncation/extension; addresses cover all DEPTH entries, no out-of-range case.
// CONFIGURATION
//  REGFILE_ZERO_REG_EN defined: entry 0 hardwired; reads of addr 0 return 0 (bypass ignored),
//    writes to addr 0 discarded, no collision reported for addr 0 (both-port writes to 0 count as no write).
//  Not defined: entry 0 is an ordinary register, identical behaviour to all other entries.
// TESTING (DATA_W=16, ADDR_W=4)
//  1 reset_n=0 2 cycles, release -> busy=1 for 16 edges, then 0; all 16 entries read 16'h0000.
//  2 READY: writeA addr 3 data 16'h0010 -> same cycle rdAddrA=3 gives 16'h0010; next cycle from mem 16'h0010.
//  3 writeA addr 5 16'hAAAA + writeB addr 5 16'h5555 same edge -> mem[5]=16'h5555, collision=1 one cycle.
//  4 During sweep (busy=1) writeA addr 2 16'hFFFF -> ignored; after busy falls rdAddrA=2 reads 16'h0000.
//  5 Fill entries with 16'h1234, assert reset_n=0 at sweep cycle 7 -> restart; busy 16 more edges; all 0.
//  6 REGFILE_ZERO_REG_EN: writeB addr 0 16'hBEEF -> rdData for addr 0 is 16'h0000 same and next cycle.

Source files
------------

// File: rtl/register_file_mp.sv
// Multi-port register file: two combinational read ports with write-first
// bypass, two write ports (port B has priority), a self-clearing sweep after
// reset that holds busy high, and a registered same-address collision pulse.
// Optional feature: define REGFILE_ZERO_REG_EN to hardwire entry 0 to zero.
module register_file_mp #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] wrAddrA,
  input  logic [DATA_W-1:0] wrDataA,
  input  logic              writeA,
  input  logic [ADDR_W-1:0] wrAddrB,
  input  logic [DATA_W-1:0] wrDataB,
  input  logic              writeB,
  input  logic [ADDR_W-1:0] rdAddrA,
  input  logic [ADDR_W-1:0] rdAddrB,
  output logic [DATA_W-1:0] rdDataA,
  output logic [DATA_W-1:0] rdDataB,
  output logic              busy,
  output logic              collision
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ENTRY = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t state;
  state_t state_next;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic wr_a_en;
  logic wr_b_en;
  logic wr_a_commit;
  logic rd_a_zero;
  logic rd_b_zero;

  // Writes only count outside busy; with the zero register, address 0 is
  // treated as if no write happened at all (no bypass, no collision).
  assign busy    = (state == CLEAR) | ~reset_n;
  assign wr_a_en = writeA & ~busy & ~(ZERO_REG && (wrAddrA == '0));
  assign wr_b_en = writeB & ~busy & ~(ZERO_REG && (wrAddrB == '0));
  assign wr_a_commit = wr_a_en & ~(wr_b_en & (wrAddrB == wrAddrA));
  assign rd_a_zero = ZERO_REG && (rdAddrA == '0);
  assign rd_b_zero = ZERO_REG && (rdAddrB == '0);

  // State, sweep counter and collision flag; reset always restarts the sweep at entry 0.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= CLEAR;
      clr_cnt   <= '0;
      collision <= 1'b0;
    end else begin
      state     <= state_next;
      collision <= wr_a_en & wr_b_en & (wrAddrA == wrAddrB);
      if (state == CLEAR) begin
        clr_cnt <= clr_cnt + ONE;
      end
    end
  end

  // Leave the clear sweep once the last entry has been zeroed.
  always_comb begin
    state_next = state;
    if ((state == CLEAR) && (clr_cnt == LAST_ENTRY)) begin
      state_next = READY;
    end
  end

  // Storage update: sweep zeroes one entry per cycle, otherwise port B overrides port A on a shared address.
  always_ff @(posedge clock) begin
    if (reset_n) begin
      if (state == CLEAR) begin
        mem[clr_cnt] <= '0;
      end else begin
        if (wr_a_commit) begin
          mem[wrAddrA] <= wrDataA;
        end
        if (wr_b_en) begin
          mem[wrAddrB] <= wrDataB;
        end
      end
    end
  end

  // Read port A: write-first bypass, B before A, else stored value.
  always_comb begin
    rdDataA = mem[rdAddrA];
    if (busy || rd_a_zero) begin
      rdDataA = '0;
    end else if (wr_b_en && (wrAddrB == rdAddrA)) begin
      rdDataA = wrDataB;
    end else if (wr_a_en && (wrAddrA == rdAddrA)) begin
      rdDataA = wrDataA;
    end
  end

  // Read port B: same selection as port A, independent address.
  always_comb begin
    rdDataB = mem[rdAddrB];
    if (busy || rd_b_zero) begin
      rdDataB = '0;
    end else if (wr_b_en && (wrAddrB == rdAddrB)) begin
      rdDataB = wrDataB;
    end else if (wr_a_en && (wrAddrA == rdAddrB)) begin
      rdDataB = wrDataA;
    end
  end

endmodule
